// File: rtl/mcu_spi_target.sv
// mcu_spi_target: SPI target (mode 0, MSB first), sampled on the fabric clock.
// Deserialises the MCU link into a start pulse per frame and one per-target
// strobe per payload byte. The reply byte on mcu_din is shifted back on spi_miso.
// Optional build macro: MCU_SPI_TIMEOUT_EN aborts a frame after TIMEOUT clk
// cycles without any SCLK edge.
module mcu_spi_target #(
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_csn,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    input  logic [7:0] mcu_din,
    output logic [7:0] mcu_data,
    output logic       mcu_start,
    output logic       mcu_sys_strobe,
    output logic       mcu_hid_strobe,
    output logic       mcu_osd_strobe,
    output logic       mcu_sdc_strobe
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, TARGET, DATA} state_t;

    logic       r_csn_m, r_csn_s;
    logic       r_sclk_m, r_sclk_s, r_sclk_d;
    logic       r_mosi_m, r_mosi_s;
    state_t     r_state, w_next;
    logic [2:0] r_bitcnt;
    logic [6:0] r_shift;
    logic [7:0] r_target;
    logic [7:0] r_pend_byte;
    logic       r_pend_start;
    logic [3:0] r_pend_sel;
    logic [7:0] r_reply;
    logic       r_skip;
    logic       w_rise, w_fall, w_shift_en, w_done, w_timeout, w_pulse, w_in_frame;
    logic [7:0] w_byte;

    assign w_rise     = r_sclk_s & ~r_sclk_d;
    assign w_fall     = ~r_sclk_s & r_sclk_d;
    assign w_byte     = {r_shift, r_mosi_s};
    assign w_in_frame = (r_state == TARGET) || (r_state == DATA);
    assign w_pulse    = mcu_start | mcu_sys_strobe | mcu_hid_strobe |
                        mcu_osd_strobe | mcu_sdc_strobe;

    // Two-stage synchronisers plus the SCLK edge-detect delay. CS resets to
    // "asserted" so WAIT_IDLE only leaves on a genuinely high chip select.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_csn_m  <= 1'b0;
            r_csn_s  <= 1'b0;
            r_sclk_m <= 1'b0;
            r_sclk_s <= 1'b0;
            r_sclk_d <= 1'b0;
            r_mosi_m <= 1'b0;
            r_mosi_s <= 1'b0;
        end else begin
            r_csn_m  <= spi_csn;
            r_csn_s  <= r_csn_m;
            r_sclk_m <= spi_sclk;
            r_sclk_s <= r_sclk_m;
            r_sclk_d <= r_sclk_s;
            r_mosi_m <= spi_mosi;
            r_mosi_s <= r_mosi_m;
        end
    end

`ifdef MCU_SPI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tcnt;

    // Stall counter: runs inside a frame, restarts on every SCLK edge.
    always_ff @(posedge clk) begin
        if (reset || !w_in_frame || w_rise || w_fall) begin
            r_tcnt <= '0;
        end else if (r_tcnt != TW'(TIMEOUT)) begin
            r_tcnt <= r_tcnt + TW'(1);
        end
    end
    assign w_timeout = (r_tcnt == TW'(TIMEOUT));
`else
    // No stall counter in this build; the comparison is constant false.
    assign w_timeout = (TIMEOUT < 0);
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= WAIT_IDLE;
        else       r_state <= w_next;
    end

    // Next state and bit strobes. CS is evaluated before SCLK, so a rise in
    // the same cycle as the CS fall is taken as bit 0 of the frame.
    always_comb begin
        w_next     = r_state;
        w_shift_en = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            WAIT_IDLE: if (r_csn_s) w_next = IDLE;
            IDLE: begin
                if (!r_csn_s) begin
                    w_next     = TARGET;
                    w_shift_en = w_rise;
                end
            end
            TARGET, DATA: begin
                if (r_csn_s) begin
                    w_next = IDLE;
                end else if (w_timeout) begin
                    w_next = WAIT_IDLE;
                end else begin
                    w_shift_en = w_rise;
                    if (w_rise && r_bitcnt == 3'd7) begin
                        w_done = 1'b1;
                        if (r_state == TARGET) w_next = DATA;
                    end
                end
            end
            default: w_next = WAIT_IDLE;
        endcase
    end

    // MOSI shifter and bit counter; partial bytes vanish whenever the frame ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else if (w_shift_en) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
        end else if (w_next != TARGET && w_next != DATA) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end
    end

    // Completed byte: latch target, stage the pulse selection for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_start <= 1'b0;
            r_pend_sel   <= '0;
            r_pend_byte  <= '0;
            r_target     <= '0;
        end else begin
            r_pend_start <= w_done && (r_state == TARGET);
            r_pend_sel   <= '0;
            if (w_done && r_state == DATA) begin
                case (r_target)
                    8'd1:    r_pend_sel <= 4'b0001;
                    8'd2:    r_pend_sel <= 4'b0010;
                    8'd3:    r_pend_sel <= 4'b0100;
                    8'd4:    r_pend_sel <= 4'b1000;
                    default: r_pend_sel <= 4'b0000;
                endcase
            end
            if (w_done) r_pend_byte <= w_byte;
            if (w_done && r_state == TARGET) r_target <= w_byte;
        end
    end

    // Output register stage; data only updates alongside a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcu_start      <= 1'b0;
            mcu_sys_strobe <= 1'b0;
            mcu_hid_strobe <= 1'b0;
            mcu_osd_strobe <= 1'b0;
            mcu_sdc_strobe <= 1'b0;
            mcu_data       <= '0;
        end else begin
            mcu_start      <= r_pend_start;
            mcu_sys_strobe <= r_pend_sel[0];
            mcu_hid_strobe <= r_pend_sel[1];
            mcu_osd_strobe <= r_pend_sel[2];
            mcu_sdc_strobe <= r_pend_sel[3];
            if (r_pend_start || (|r_pend_sel)) mcu_data <= r_pend_byte;
        end
    end

    // Reply shifter. The load lands while SCLK is still high after bit 8, so
    // the falling edge that closes that bit must not shift, otherwise the MCU
    // would miss bit 7 of the reply on its next rising edge.
    always_ff @(posedge clk) begin
        if (reset || !w_in_frame) begin
            r_reply <= '0;
            r_skip  <= 1'b0;
        end else if (w_pulse) begin
            r_reply <= mcu_din;
            r_skip  <= 1'b1;
        end else if (w_fall) begin
            if (r_skip) r_skip  <= 1'b0;
            else        r_reply <= {r_reply[6:0], 1'b0};
        end
    end

    assign spi_miso = w_in_frame & (w_pulse ? mcu_din[7] : r_reply[7]);

endmodule

// File: tb/tb_mcu_spi_target.sv
// Scoreboard bench for mcu_spi_target: expected pulses are queued as bytes are
// sent and popped by a monitor when the DUT fires start/strobe outputs.
module tb_mcu_spi_target;

    localparam int HALF = 8;

    localparam logic [4:0] K_START = 5'b00001;
    localparam logic [4:0] K_SYS   = 5'b00010;
    localparam logic [4:0] K_HID   = 5'b00100;
    localparam logic [4:0] K_OSD   = 5'b01000;
    localparam logic [4:0] K_SDC   = 5'b10000;

    typedef struct packed {
        logic [4:0] kind;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_csn = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic [7:0] mcu_din = 8'h00;
    logic [7:0] mcu_data;
    logic       mcu_start, mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe;

    exp_t       sb[$];
    exp_t       m_exp;
    logic [4:0] m_pulses;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] rx;

    mcu_spi_target #(.TIMEOUT(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .spi_csn        (spi_csn),
        .spi_sclk       (spi_sclk),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .mcu_din        (mcu_din),
        .mcu_data       (mcu_data),
        .mcu_start      (mcu_start),
        .mcu_sys_strobe (mcu_sys_strobe),
        .mcu_hid_strobe (mcu_hid_strobe),
        .mcu_osd_strobe (mcu_osd_strobe),
        .mcu_sdc_strobe (mcu_sdc_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: every pulse must be single-hot and match the queue head.
    always @(negedge clk) begin
        m_pulses = {mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe, mcu_start};
        if (m_pulses != 5'b0) begin
            chk("onehot", $countones(m_pulses), 1);
            if (sb.size() == 0) begin
                chk("sb_unexpected", sb.size(), 1);
            end else begin
                m_exp = sb.pop_front();
                chk("sb_kind", m_pulses, m_exp.kind);
                chk("sb_data", mcu_data, m_exp.data);
            end
        end
    end

    task automatic push(input logic [4:0] k, input logic [7:0] d);
        sb.push_back('{kind: k, data: d});
    endtask

    task automatic hb();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_csn = 1'b0;
        hb();
    endtask

    task automatic cs_high();
        hb();
        spi_csn = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    // Mode 0: MOSI set while SCLK low, MISO sampled just before the rise.
    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = b[7-i];
            hb();
            r = {r[6:0], spi_miso};
            spi_sclk = 1'b1;
            hb();
            spi_sclk = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pulses", {mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe, mcu_start}, 0);
        chk("rst_data", mcu_data, 0);
        chk("rst_miso", spi_miso, 0);
        repeat (10) @(negedge clk);

        // OSD target, two payload bytes
        push(K_START, 8'h03); push(K_OSD, 8'hA5); push(K_OSD, 8'h5A);
        cs_low();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'hA5, 8, rx);
        spi_bits(8'h5A, 8, rx);
        cs_high();
        drain("t1_osd");

        // System target with reply byte
        mcu_din = 8'hC3;
        push(K_START, 8'h01); push(K_SYS, 8'h12);
        cs_low();
        spi_bits(8'h01, 8, rx);
        chk("t2_miso0", rx, 8'h00);
        spi_bits(8'h12, 8, rx);
        chk("t2_miso1", rx, 8'hC3);
        cs_high();
        drain("t2_sys");
        mcu_din = 8'h00;

        // Unknown target drops payload; next frame goes to HID
        push(K_START, 8'h07);
        cs_low();
        spi_bits(8'h07, 8, rx);
        spi_bits(8'hFF, 8, rx);
        cs_high();
        drain("t3_drop");
        push(K_START, 8'h02); push(K_HID, 8'h44);
        cs_low();
        spi_bits(8'h02, 8, rx);
        spi_bits(8'h44, 8, rx);
        cs_high();
        drain("t3_hid");

        // CS raised mid-byte: partial byte discarded
        push(K_START, 8'h04);
        cs_low();
        spi_bits(8'h04, 8, rx);
        spi_bits(8'h81, 5, rx);
        cs_high();
        drain("t4_partial");
        push(K_START, 8'h04); push(K_SDC, 8'h81);
        cs_low();
        spi_bits(8'h04, 8, rx);
        spi_bits(8'h81, 8, rx);
        cs_high();
        drain("t4_sdc");

        // Reset mid-frame while clocking continues: silent until a new CS cycle
        push(K_START, 8'h03);
        cs_low();
        spi_bits(8'h03, 8, rx);
        drain("t5_pre");
        spi_bits(8'h55, 4, rx);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("t5_rst_data", mcu_data, 0);
        spi_bits(8'h50, 4, rx);
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h11, 8, rx);
        chk("t5_miso", rx, 8'h00);
        cs_high();
        push(K_START, 8'h03); push(K_OSD, 8'h22);
        cs_low();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h22, 8, rx);
        cs_high();
        drain("t5_after");

`ifdef MCU_SPI_TIMEOUT_EN
        // Stalled frame times out; further clocking with CS low is ignored
        cs_low();
        spi_bits(8'hE0, 3, rx);
        repeat (100) @(negedge clk);
        spi_bits(8'h03, 8, rx);
        chk("t6_miso", rx, 8'h00);
        cs_high();
        push(K_START, 8'h03); push(K_OSD, 8'h10);
        cs_low();
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h10, 8, rx);
        cs_high();
        drain("t6_osd");
`endif

        repeat (20) @(negedge clk);
        chk("sb_final", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
